// File: rtl/userkey_debounce_pkg.sv
// Shared constants for the user-key debounce device: key count, bus widths, register offsets.
package userkey_debounce_pkg;

    localparam int unsigned NUM_KEYS = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 32;

    // Word offsets within the device window
    typedef enum logic [ADDR_W-1:0] {
        UKD_STATE = 3'd0,
        UKD_PEND  = 3'd1,
        UKD_MASK  = 3'd2,
        UKD_RAW   = 3'd3
    } ukd_reg_e;

    // Zero-extend a per-key vector onto the read bus
    function automatic logic [DATA_W-1:0] key_word(input logic [NUM_KEYS-1:0] v);
        return DATA_W'(v);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, stability counter, accepted state and a one-cycle press pulse.
module key_debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic sync,
    output logic stable,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchroniser; resets to the released (high) pin level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= key_n;
            sync_q <= meta_q;
        end
    end

    // Active-high pressed level
    assign sync = ~sync_q;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync == stable) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                stable <= sync;
                press  <= sync;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/userkey_debounce.sv
// Bridge-attached debounced user keys with latched press events and a maskable interrupt.
module userkey_debounce
    import userkey_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] user_key,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic                WE,
    input  logic [DATA_W-1:0]   DIn,
    output logic [DATA_W-1:0]   RD,
    output logic                IRQ
);

    logic [NUM_KEYS-1:0] key_sync;
    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] pending_q;
    logic [NUM_KEYS-1:0] mask_q;
    logic [NUM_KEYS-1:0] pend_clr;
    logic                mask_we;
    logic                unused_din;

    // Only the low byte of the store data is meaningful
    assign unused_din = ^DIn[DATA_W-1:NUM_KEYS];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .key_n (user_key[i]),
            .sync  (key_sync[i]),
            .stable(key_stable[i]),
            .press (key_press[i])
        );
    end

    // Decode bridge stores into clear/mask strobes
    always_comb begin
        pend_clr = '0;
        mask_we  = 1'b0;
        if (WE) begin
            if (Addr == UKD_PEND) pend_clr = DIn[NUM_KEYS-1:0];
            if (Addr == UKD_MASK) mask_we  = 1'b1;
        end
    end

    // Pending press latch (set beats write-one-clear), mask register, interrupt flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            IRQ       <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | key_press;
            if (mask_we) mask_q <= DIn[NUM_KEYS-1:0];
            IRQ <= |(pending_q & mask_q);
        end
    end

    // Combinational read mux; unmapped offsets read zero
    always_comb begin
        RD = '0;
        case (Addr)
            UKD_STATE: RD = key_word(key_stable);
            UKD_PEND:  RD = key_word(pending_q);
            UKD_MASK:  RD = key_word(mask_q);
            UKD_RAW:   RD = key_word(key_sync);
            default:   RD = '0;
        endcase
    end

endmodule

// File: tb/tb_userkey_debounce.sv
// Randomised self-checking bench for userkey_debounce against a window-based reference model.
module tb_userkey_debounce;

    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  user_key;
    logic [2:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] RD;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pin pipeline, last-DB-samples window per key, registers
    logic [7:0]    m_s1, m_s2, m_stable, m_press, m_pend, m_mask;
    logic          m_irq;
    logic [DB-1:0] m_hist [8];

    userkey_debounce #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .user_key(user_key),
        .Addr    (Addr),
        .WE      (WE),
        .DIn     (DIn),
        .RD      (RD),
        .IRQ     (IRQ)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_stable};
            3'd1:    return {24'd0, m_pend};
            3'd2:    return {24'd0, m_mask};
            3'd3:    return {24'd0, ~m_s2};
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock edge and update the model from the inputs seen at that edge
    task automatic tick();
        logic [7:0] clr;
        logic [7:0] nstable;
        logic       irq_n;
        @(posedge clk);
        if (reset) begin
            m_s1 = 8'hFF; m_s2 = 8'hFF; m_stable = '0; m_press = '0;
            m_pend = '0; m_mask = '0; m_irq = 1'b0;
            for (int k = 0; k < 8; k++) m_hist[k] = '0;
        end else begin
            clr   = (WE && Addr == 3'd1) ? DIn[7:0] : 8'h00;
            irq_n = |(m_pend & m_mask);
            m_pend = (m_pend & ~clr) | m_press;
            if (WE && Addr == 3'd2) m_mask = DIn[7:0];
            nstable = m_stable;
            for (int k = 0; k < 8; k++) begin
                m_hist[k] = {m_hist[k][DB-2:0], ~m_s2[k]};
                if (m_hist[k] == {DB{~m_stable[k]}}) nstable[k] = ~m_stable[k];
            end
            m_press  = nstable & ~m_stable;
            m_stable = nstable;
            m_s2     = m_s1;
            m_s1     = user_key;
            m_irq    = irq_n;
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        WE = 1'b1; Addr = a; DIn = d;
        tick();
        WE = 1'b0; DIn = '0;
    endtask

    task automatic settle_and_clear();
        user_key = 8'hFF;
        repeat (8) tick();
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'h00);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; user_key = 8'hFF; WE = 1'b0; Addr = '0; DIn = '0;
        repeat (3) tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            Addr = 3'(a); #1;
            n_checks++;
            if (RD !== 32'h0 || IRQ !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state addr=%0d: RD=%h IRQ=%b, expected RD=00000000 IRQ=0", a, RD, IRQ);
            end
        end
        user_key[2] = 1'b0;
        repeat (4) tick();
        reset = 1'b1; #1;
        for (int a = 0; a < 4; a++) begin
            Addr = 3'(a); #1;
            n_checks++;
            if (RD !== 32'h0 || IRQ !== 1'b0) begin
                n_errors++;
                $display("FAIL async_reset addr=%0d: RD=%h IRQ=%b, expected RD=00000000 IRQ=0", a, RD, IRQ);
            end
        end
        user_key = 8'hFF;
        repeat (2) tick();
        reset = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            Addr = 3'(t % 4); #1;
            n_checks++;
            if (RD !== 32'h0 || RD !== rd_model(Addr) || IRQ !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_no_event t=%0d addr=%0d: RD=%h IRQ=%b, expected RD=00000000 IRQ=0", t, Addr, RD, IRQ);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] exp_rd;
        wr(3'd2, 32'h01);
        user_key[0] = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            Addr = (t == 7) ? 3'd1 : 3'd0; #1;
            n_checks++;
            if (RD !== rd_model(Addr) || IRQ !== m_irq) begin
                n_errors++;
                $display("FAIL clean_press_model t=%0d addr=%0d: RD=%h IRQ=%b, expected RD=%h IRQ=%b", t, Addr, RD, IRQ, rd_model(Addr), m_irq);
            end
            if (t >= 5 && t <= 8) begin
                exp_rd = (t >= 6) ? 32'h1 : 32'h0;
                n_checks++;
                if (RD !== exp_rd || IRQ !== (t >= 8)) begin
                    n_errors++;
                    $display("FAIL clean_press_latency t=%0d addr=%0d: RD=%h IRQ=%b, expected RD=%h IRQ=%b", t, Addr, RD, IRQ, exp_rd, (t >= 8));
                end
            end
        end
        user_key[0] = 1'b1;
        repeat (8) tick();
        Addr = 3'd0; #1;
        n_checks++;
        if (RD !== 32'h0) begin
            n_errors++;
            $display("FAIL release_state: RD=%h, expected 00000000", RD);
        end
        Addr = 3'd1; #1;
        n_checks++;
        if (RD !== 32'h1 || IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL release_pending: RD=%h IRQ=%b, expected RD=00000001 IRQ=1", RD, IRQ);
        end
        settle_and_clear();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            user_key[3] = ((i / 2) % 2 == 1);
            tick();
            Addr = 3'(i % 2); #1;
            n_checks++;
            if (RD !== 32'h0 || RD !== rd_model(Addr)) begin
                n_errors++;
                $display("FAIL bounce_reject i=%0d addr=%0d: RD=%h, expected 00000000", i, Addr, RD);
            end
        end
        user_key[3] = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            Addr = 3'd0; #1;
            n_checks++;
            if (RD !== ((t == 6) ? 32'h08 : 32'h00)) begin
                n_errors++;
                $display("FAIL bounce_hold t=%0d: RD=%h, expected %h", t, RD, (t == 6) ? 32'h08 : 32'h00);
            end
        end
        settle_and_clear();
        // random bounce widths on key 5
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) user_key[5] = ~user_key[5];
            tick();
            Addr = 3'($urandom_range(0, 3)); #1;
            n_checks++;
            if (RD !== rd_model(Addr) || IRQ !== m_irq) begin
                n_errors++;
                $display("FAIL bounce_random i=%0d addr=%0d: RD=%h IRQ=%b, expected RD=%h IRQ=%b", i, Addr, RD, IRQ, rd_model(Addr), m_irq);
            end
        end
        settle_and_clear();
    endtask

    task automatic test_w1c();
        user_key = 8'h7E;
        repeat (8) tick();
        user_key = 8'hFF;
        repeat (8) tick();
        Addr = 3'd1; #1;
        n_checks++;
        if (RD !== 32'h81) begin
            n_errors++;
            $display("FAIL w1c_setup: RD=%h, expected 00000081", RD);
        end
        wr(3'd1, 32'h01);
        Addr = 3'd1; #1;
        n_checks++;
        if (RD !== 32'h80 || RD !== rd_model(3'd1)) begin
            n_errors++;
            $display("FAIL w1c_clear: RD=%h, expected 00000080", RD);
        end
        user_key[0] = 1'b0;
        for (int i = 0; i < 20 && !m_press[0]; i++) tick();
        n_checks++;
        if (m_press[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL w1c_collision_timeout: press not seen, expected within 20 cycles");
        end
        wr(3'd1, 32'h01);
        Addr = 3'd1; #1;
        n_checks++;
        if (RD !== 32'h81 || RD !== rd_model(3'd1)) begin
            n_errors++;
            $display("FAIL w1c_collision: RD=%h, expected 00000081", RD);
        end
        settle_and_clear();
    endtask

    task automatic test_mask();
        wr(3'd2, 32'h00);
        user_key[4] = 1'b0;
        repeat (8) tick();
        user_key[4] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            Addr = 3'd1; #1;
            n_checks++;
            if (IRQ !== 1'b0 || RD !== rd_model(3'd1)) begin
                n_errors++;
                $display("FAIL mask_off t=%0d: RD=%h IRQ=%b, expected RD=%h IRQ=0", t, RD, IRQ, rd_model(3'd1));
            end
        end
        wr(3'd2, 32'h10);
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL mask_set_edge: IRQ=%b, expected 0", IRQ);
        end
        tick();
        n_checks++;
        if (IRQ !== 1'b1 || IRQ !== m_irq) begin
            n_errors++;
            $display("FAIL mask_set_next: IRQ=%b, expected 1", IRQ);
        end
        wr(3'd1, 32'h10);
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_edge: IRQ=%b, expected 1", IRQ);
        end
        tick();
        n_checks++;
        if (IRQ !== 1'b0 || IRQ !== m_irq) begin
            n_errors++;
            $display("FAIL clear_next: IRQ=%b, expected 0", IRQ);
        end
        settle_and_clear();
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_rd;
        user_key = 8'hBD;
        for (int t = 1; t <= 7; t++) begin
            tick();
            Addr = (t <= 2) ? 3'd3 : 3'd1; #1;
            exp_rd = 32'h0;
            if (t == 2 || t == 7) exp_rd = 32'h42;
            if (t <= 2 || t >= 6) begin
                n_checks++;
                if (RD !== exp_rd || RD !== rd_model(Addr)) begin
                    n_errors++;
                    $display("FAIL simultaneous t=%0d addr=%0d: RD=%h, expected %h", t, Addr, RD, exp_rd);
                end
            end
        end
        settle_and_clear();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) user_key[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) wr(3'($urandom_range(0, 7)), $urandom());
            else tick();
            Addr = 3'($urandom_range(0, 7)); #1;
            n_checks++;
            if (RD !== rd_model(Addr) || IRQ !== m_irq) begin
                n_errors++;
                $display("FAIL random i=%0d addr=%0d: RD=%h IRQ=%b, expected RD=%h IRQ=%b", i, Addr, RD, IRQ, rd_model(Addr), m_irq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_w1c();
        test_mask();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
